lc3_mmio_devices: RTL and testbench
===================================

# lc3_mmio_devices

Memory-mapped keyboard/display device block for the LC-3 core. It sits directly on the datapath's I/O side: it decodes the MAR address for the I/O page at 0xFE00 and above, and returns read data into the MDR input mux. It also consumes MDR write data and the I/O write strobe. A 4-entry keyboard receive FIFO, a display transmit holding register and an interrupt presenter drive the datapath's IRQ/INTP/INTV inputs.

## Interface
- KBD_DEPTH, 4, keyboard FIFO depth (power of 2, ≥2)
- KBD_INTP, 3'd4, keyboard interrupt priority
- KBD_INTV, 8'h80, keyboard interrupt vector
- DSP_INTP, 3'd3, display interrupt priority
- DSP_INTV, 8'h81, display interrupt vector
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mmio_addr  in  16  access address (datapath MAR)
- mmio_wdata  in  16  write data (datapath MDR)
- mmio_load  in  1  I/O write strobe, one cycle
- mmio_rd  in  1  I/O read strobe: control pulses it in the cycle the MDR loads from I/O space
- mmio_rdata  out  16  read data to the datapath INMUX (combinational)
- kbd_data  in  8  received character
- kbd_valid  in  1  one-cycle strobe, character present (no back-pressure)
- kbd_ready  out  1  FIFO not full (informational)
- dsp_data  out  8  character to display
- dsp_valid  out  1  holding register full
- dsp_ready  in  1  display accepts the character when high with dsp_valid
- irq  out  1  one-cycle pulse: intp/intv changed
- intp  out  3  priority of the highest pending interrupt, 0 if none
- intv  out  8  vector of the presented interrupt, 0 if none

## Operation
- Decode uses a full 16-bit compare. Only the addresses below are valid; any other address reads 0x0000 and writes are ignored.
- KBSR 0xFE00: [15] ready = FIFO non-empty, [14] IE, [13] OVF (sticky), all other bits 0.
  - Write: IE <= wdata[14]. If wdata[13]=1, OVF is cleared.
- KBDR 0xFE02: read returns {8'h00, FIFO head}. mmio_rd pops the FIFO when it is non-empty. A read while empty returns 0x0000 and does not pop. Writes are ignored.
- DSR 0xFE04: [15] ready = ~dsp_valid, [14] IE.
  - Write: IE <= wdata[14].
- DDR 0xFE06: a write loads the holding register with wdata[7:0] and sets dsp_valid. A write while not ready is dropped. Read returns {8'h00, last written byte}.
- If mmio_load and mmio_rd are both high, the access is treated as a write only (no pop).
- Keyboard FIFO:
  - Push on kbd_valid when not full.
  - kbd_valid while full drops the character and sets OVF. The exception is a simultaneous pop: the pop frees a slot first, the push is accepted, and count is unchanged.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps count unchanged and preserves order.
  - Pointers wrap modulo KBD_DEPTH.
- Display transfer:
  - dsp_valid & dsp_ready clears dsp_valid.
  - A DDR write in that same cycle is accepted: the holding register reloads and dsp_valid stays 1.
- Interrupts:
  - kbd_pend = KBSR.IE & KBSR.ready; dsp_pend = DSR.IE & DSR.ready.
  - Selection: the pending source with the higher INTP wins; on a tie the keyboard wins. With nothing pending the selection is {0, 0}.
  - The selection is registered into intp/intv. irq pulses for one cycle whenever the registered value changes, including a drop to 0, so the datapath's INTP latch tracks it.

## Timing
- Reset values:
  - Outputs: kbd_ready=1, dsp_valid=0, dsp_data=0, irq=0, intp=0, intv=0.
  - Internal state: FIFO empty, both IE bits 0, OVF 0, holding register 0.
  - mmio_rdata follows decode (KBSR reads 0x0000, DSR reads 0x8000).
- Reset asserted mid-operation clears all state immediately; in-flight data is lost.
- Writes and pops take effect at the clk edge where the strobe is high. Status reflects the change in the following cycle.
- A kbd_valid push at edge n gives KBSR.ready=1 and the new head in cycle n+1.
- Interrupt latency: pending state changes at edge n; intp/intv update and irq pulses at edge n+1.
- The FIFO has one-cycle latency from push to readable. A pop at edge n presents the next head in cycle n+1.

## Test plan
- Reset, then read FE00/FE04/FE06 -> 0x0000, 0x8000, 0x0000; kbd_ready=1; irq never pulses.
- Push 0x41, 0x42, 0x43, then three KBDR reads with mmio_rd -> 0x0041, 0x0042, 0x0043; KBSR[15] goes 1 after the first push and 0 after the third pop; a fourth read -> 0x0000.
- Push 5 characters with no pops -> 5th dropped, KBSR=0x2000|0x8000; push while full with a simultaneous pop -> accepted, count stays 4; write FE00 0x2000 -> OVF cleared.
- Write FE02 = 0x4000?? (ignored); write FE00=0x4000, then push 0x55 -> one cycle later intp=4, intv=0x80, irq pulses once; pop -> intp=0, intv=0, irq pulses again.
- Write FE06=0x0058 with dsp_ready=0 -> dsp_valid=1, dsp_data=0x58, DSR=0x0000; second write 0x59 dropped; dsp_ready=1 for one cycle -> dsp_valid=0, DSR=0x8000; a write during a ready cycle keeps dsp_valid=1 with the new data.
- Both IEs set, keyboard non-empty, display ready -> intp=4, intv=0x80; set KBD_INTP=3 (tie) -> keyboard still wins; disable the keyboard IE -> intp=3, intv=0x81 with one irq pulse.

Source files
------------

// File: rtl/lc3_mmio_devices.sv
// rtl/lc3_mmio_devices.sv - LC-3 keyboard/display MMIO block with receive FIFO and interrupt presenter

// Keyboard receive queue: a circular buffer with an occupancy counter.
// A push while full is taken only when a pop frees a slot in the same cycle.
module lc3_kbd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module lc3_mmio_devices #(
    parameter int         KBD_DEPTH = 4,
    parameter logic [2:0] KBD_INTP  = 3'd4,
    parameter logic [7:0] KBD_INTV  = 8'h80,
    parameter logic [2:0] DSP_INTP  = 3'd3,
    parameter logic [7:0] DSP_INTV  = 8'h81
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mmio_addr,
    input  logic [15:0] mmio_wdata,
    input  logic        mmio_load,
    input  logic        mmio_rd,
    output logic [15:0] mmio_rdata,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    output logic [7:0]  dsp_data,
    output logic        dsp_valid,
    input  logic        dsp_ready,
    output logic        irq,
    output logic [2:0]  intp,
    output logic [7:0]  intv
);
    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    logic       sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
    logic       kbd_ie, kbd_ovf, dsp_ie;
    logic       kbd_empty, kbd_full, kbd_pop, kbd_drop;
    logic [7:0] kbd_head;
    logic       ddr_accept;
    logic       kbd_pend, dsp_pend;
    logic [2:0] sel_intp;
    logic [7:0] sel_intv;
    logic       wdata_unused;

    assign sel_kbsr = (mmio_addr == ADDR_KBSR);
    assign sel_kbdr = (mmio_addr == ADDR_KBDR);
    assign sel_dsr  = (mmio_addr == ADDR_DSR);
    assign sel_ddr  = (mmio_addr == ADDR_DDR);

    // A combined load+read strobe is a write, so it never pops.
    assign kbd_pop    = mmio_rd & ~mmio_load & sel_kbdr & ~kbd_empty;
    assign kbd_drop   = kbd_valid & kbd_full & ~kbd_pop;
    assign kbd_ready  = ~kbd_full;
    // The holding register can reload in the very cycle the display drains it.
    assign ddr_accept = mmio_load & sel_ddr & (~dsp_valid | dsp_ready);

    assign wdata_unused = ^{mmio_wdata[15], mmio_wdata[12:8]};

    lc3_kbd_fifo #(
        .DEPTH (KBD_DEPTH),
        .WIDTH (8)
    ) u_kbd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (kbd_valid),
        .push_data (kbd_data),
        .pop       (kbd_pop),
        .head      (kbd_head),
        .empty     (kbd_empty),
        .full      (kbd_full)
    );

    // Status/control registers and display holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbd_ie    <= 1'b0;
            kbd_ovf   <= 1'b0;
            dsp_ie    <= 1'b0;
            dsp_valid <= 1'b0;
            dsp_data  <= 8'h00;
        end else begin
            if (mmio_load && sel_kbsr) begin
                kbd_ie <= mmio_wdata[14];
                if (mmio_wdata[13]) kbd_ovf <= 1'b0;
            end
            // A fresh overflow outranks a same-cycle clear so the event is not lost.
            if (kbd_drop) kbd_ovf <= 1'b1;
            if (mmio_load && sel_dsr) dsp_ie <= mmio_wdata[14];
            if (ddr_accept) begin
                dsp_data  <= mmio_wdata[7:0];
                dsp_valid <= 1'b1;
            end else if (dsp_valid && dsp_ready) begin
                dsp_valid <= 1'b0;
            end
        end
    end

    // Read-data mux into the datapath; unmapped addresses read zero.
    always_comb begin
        mmio_rdata = 16'h0000;
        case (mmio_addr)
            ADDR_KBSR: mmio_rdata = {~kbd_empty, kbd_ie, kbd_ovf, 13'h0000};
            ADDR_KBDR: mmio_rdata = kbd_empty ? 16'h0000 : {8'h00, kbd_head};
            ADDR_DSR:  mmio_rdata = {~dsp_valid, dsp_ie, 14'h0000};
            ADDR_DDR:  mmio_rdata = {8'h00, dsp_data};
            default:   mmio_rdata = 16'h0000;
        endcase
    end

    assign kbd_pend = kbd_ie & ~kbd_empty;
    assign dsp_pend = dsp_ie & ~dsp_valid;

    // Priority select; the keyboard wins ties.
    always_comb begin
        sel_intp = 3'd0;
        sel_intv = 8'h00;
        if (kbd_pend && (!dsp_pend || (KBD_INTP >= DSP_INTP))) begin
            sel_intp = KBD_INTP;
            sel_intv = KBD_INTV;
        end else if (dsp_pend) begin
            sel_intp = DSP_INTP;
            sel_intv = DSP_INTV;
        end
    end

    // Registered presentation; irq flags any change, including a drop to none.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intp <= 3'd0;
            intv <= 8'h00;
            irq  <= 1'b0;
        end else begin
            intp <= sel_intp;
            intv <= sel_intv;
            irq  <= ({sel_intp, sel_intv} != {intp, intv});
        end
    end
endmodule

// File: tb/tb_lc3_mmio_devices.sv
// tb/tb_lc3_mmio_devices.sv - self-checking bench for lc3_mmio_devices
module tb_lc3_mmio_devices;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mmio_addr = 16'h0000;
    logic [15:0] mmio_wdata = 16'h0000;
    logic        mmio_load = 1'b0;
    logic        mmio_rd = 1'b0;
    logic [7:0]  kbd_data = 8'h00;
    logic        kbd_valid = 1'b0;
    logic        dsp_ready = 1'b0;
    logic [15:0] mmio_rdata, t_rdata;
    logic        kbd_ready, t_kbd_ready;
    logic [7:0]  dsp_data, t_dsp_data;
    logic        dsp_valid, t_dsp_valid;
    logic        irq, t_irq;
    logic [2:0]  intp, t_intp;
    logic [7:0]  intv, t_intv;

    int checks = 0;
    int errors = 0;

    lc3_mmio_devices dut (
        .clk(clk), .rst(rst), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_load(mmio_load), .mmio_rd(mmio_rd), .mmio_rdata(mmio_rdata),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
        .dsp_data(dsp_data), .dsp_valid(dsp_valid), .dsp_ready(dsp_ready),
        .irq(irq), .intp(intp), .intv(intv)
    );

    // Same stimulus, keyboard priority tied with the display.
    lc3_mmio_devices #(.KBD_INTP(3'd3)) dut_tie (
        .clk(clk), .rst(rst), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_load(mmio_load), .mmio_rd(mmio_rd), .mmio_rdata(t_rdata),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(t_kbd_ready),
        .dsp_data(t_dsp_data), .dsp_valid(t_dsp_valid), .dsp_ready(dsp_ready),
        .irq(t_irq), .intp(t_intp), .intv(t_intv)
    );

    always #5 clk = ~clk;

    // Reference model (default parameters).
    logic [7:0]  mq[$];
    bit          m_ovf, m_kie, m_die, m_dv, m_irq;
    logic [7:0]  m_dd;
    logic [2:0]  m_intp;
    logic [7:0]  m_intv;

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_kie = 0; m_die = 0; m_dv = 0; m_irq = 0;
        m_dd = 8'h00; m_intp = 3'd0; m_intv = 8'h00;
    endtask

    function automatic logic [10:0] m_sel();
        bit kp, dp;
        kp = m_kie && (mq.size() != 0);
        dp = m_die && !m_dv;
        if (kp) return {3'd4, 8'h80};
        if (dp) return {3'd3, 8'h81};
        return 11'd0;
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        case (a)
            16'hFE00: return {(mq.size() != 0), m_kie, m_ovf, 13'h0000};
            16'hFE02: return (mq.size() != 0) ? {8'h00, mq[0]} : 16'h0000;
            16'hFE04: return {!m_dv, m_die, 14'h0000};
            16'hFE06: return {8'h00, m_dd};
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic model_edge();
        logic [10:0] s;
        bit pop;
        if (rst) begin
            model_reset();
            return;
        end
        s = m_sel();
        m_irq = (s != {m_intp, m_intv});
        {m_intp, m_intv} = s;
        pop = mmio_rd && !mmio_load && (mmio_addr == 16'hFE02) && (mq.size() != 0);
        if (m_dv && dsp_ready) m_dv = 0;
        if (mmio_load && mmio_addr == 16'hFE06 && !m_dv) begin
            m_dd = mmio_wdata[7:0];
            m_dv = 1;
        end
        if (mmio_load && mmio_addr == 16'hFE04) m_die = mmio_wdata[14];
        if (mmio_load && mmio_addr == 16'hFE00) begin
            m_kie = mmio_wdata[14];
            if (mmio_wdata[13]) m_ovf = 0;
        end
        if (pop) void'(mq.pop_front());
        if (kbd_valid) begin
            if (mq.size() < 4) mq.push_back(kbd_data);
            else m_ovf = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        mmio_load = 0; mmio_rd = 0; kbd_valid = 0; dsp_ready = 0;
        mmio_addr = 16'h0000; mmio_wdata = 16'h0000;
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        mmio_addr = a; mmio_wdata = d; mmio_load = 1;
        step();
        mmio_load = 0;
    endtask

    task automatic push(input logic [7:0] c);
        kbd_data = c; kbd_valid = 1;
        step();
        kbd_valid = 0;
    endtask

    task automatic test_reset();
        logic [15:0] exp_r[3];
        logic [15:0] adr[3];
        exp_r[0] = 16'h0000; exp_r[1] = 16'h8000; exp_r[2] = 16'h0000;
        adr[0] = 16'hFE00; adr[1] = 16'hFE04; adr[2] = 16'hFE06;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mmio_addr = adr[i];
            #1;
            checks++;
            if (mmio_rdata !== exp_r[i]) begin
                errors++;
                $display("FAIL reset_read addr %h got %h exp %h", adr[i], mmio_rdata, exp_r[i]);
            end
        end
        checks++;
        if (kbd_ready !== 1'b1 || dsp_valid !== 1'b0 || dsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got kr=%b dv=%b dd=%h exp 1 0 00", kbd_ready, dsp_valid, dsp_data);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (irq !== 1'b0 || intp !== 3'd0 || intv !== 8'h00) begin
                errors++;
                $display("FAIL reset_irq got irq=%b intp=%0d intv=%h exp 0 0 00", irq, intp, intv);
            end
            step();
        end
    endtask

    task automatic test_kbd_fifo();
        logic [7:0] chars[3];
        chars[0] = 8'h41; chars[1] = 8'h42; chars[2] = 8'h43;
        do_reset();
        push(chars[0]);
        mmio_addr = 16'hFE00;
        #1;
        checks++;
        if (mmio_rdata !== 16'h8000) begin
            errors++;
            $display("FAIL fifo_ready_after_push got %h exp 8000", mmio_rdata);
        end
        push(chars[1]);
        push(chars[2]);
        for (int i = 0; i < 3; i++) begin
            mmio_addr = 16'hFE02; mmio_rd = 1;
            #1;
            checks++;
            if (mmio_rdata !== {8'h00, chars[i]}) begin
                errors++;
                $display("FAIL fifo_pop%0d got %h exp %h", i, mmio_rdata, {8'h00, chars[i]});
            end
            step();
            mmio_rd = 0;
        end
        mmio_addr = 16'hFE00;
        #1;
        checks++;
        if (mmio_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL fifo_empty_status got %h exp 0000", mmio_rdata);
        end
        mmio_addr = 16'hFE02; mmio_rd = 1;
        #1;
        checks++;
        if (mmio_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL fifo_read_empty got %h exp 0000", mmio_rdata);
        end
        step();
        mmio_rd = 0;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[4];
        exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h06;
        do_reset();
        for (int i = 1; i <= 5; i++) push(8'(i));
        mmio_addr = 16'hFE00;
        #1;
        checks++;
        if (mmio_rdata !== 16'hA000 || kbd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ovf_status got %h kr=%b exp a000 kr=0", mmio_rdata, kbd_ready);
        end
        mmio_addr = 16'hFE02; mmio_rd = 1; kbd_data = 8'h06; kbd_valid = 1;
        #1;
        checks++;
        if (mmio_rdata !== 16'h0001) begin
            errors++;
            $display("FAIL ovf_head got %h exp 0001", mmio_rdata);
        end
        step();
        mmio_rd = 0; kbd_valid = 0;
        mmio_addr = 16'hFE00;
        #1;
        checks++;
        if (kbd_ready !== 1'b0 || mmio_rdata !== 16'hA000) begin
            errors++;
            $display("FAIL full_push_pop got kr=%b st=%h exp kr=0 st=a000", kbd_ready, mmio_rdata);
        end
        wr(16'hFE00, 16'h2000);
        mmio_addr = 16'hFE00;
        #1;
        checks++;
        if (mmio_rdata !== 16'h8000) begin
            errors++;
            $display("FAIL ovf_clear got %h exp 8000", mmio_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            mmio_addr = 16'hFE02; mmio_rd = 1;
            #1;
            checks++;
            if (mmio_rdata !== {8'h00, exp_q[i]}) begin
                errors++;
                $display("FAIL ovf_drain%0d got %h exp %h", i, mmio_rdata, {8'h00, exp_q[i]});
            end
            step();
            mmio_rd = 0;
        end
    endtask

    task automatic test_kbd_irq();
        do_reset();
        wr(16'hFE02, 16'h4000);
        mmio_addr = 16'hFE00;
        #1;
        checks++;
        if (mmio_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL kbdr_write_ignored got %h exp 0000", mmio_rdata);
        end
        wr(16'hFE00, 16'h4000);
        step();
        checks++;
        if (mmio_rdata !== 16'h4000 || intp !== 3'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL ie_no_irq got st=%h intp=%0d irq=%b exp 4000 0 0", mmio_rdata, intp, irq);
        end
        push(8'h55);
        checks++;
        if (intp !== 3'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_latency got intp=%0d irq=%b exp 0 0", intp, irq);
        end
        step();
        checks++;
        if (intp !== 3'd4 || intv !== 8'h80 || irq !== 1'b1) begin
            errors++;
            $display("FAIL kbd_irq got intp=%0d intv=%h irq=%b exp 4 80 1", intp, intv, irq);
        end
        step();
        checks++;
        if (irq !== 1'b0 || intp !== 3'd4) begin
            errors++;
            $display("FAIL kbd_irq_once got irq=%b intp=%0d exp 0 4", irq, intp);
        end
        mmio_addr = 16'hFE02; mmio_rd = 1;
        step();
        mmio_rd = 0;
        step();
        checks++;
        if (intp !== 3'd0 || intv !== 8'h00 || irq !== 1'b1) begin
            errors++;
            $display("FAIL kbd_irq_drop got intp=%0d intv=%h irq=%b exp 0 00 1", intp, intv, irq);
        end
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL kbd_irq_drop_once got irq=%b exp 0", irq);
        end
    endtask

    task automatic test_display();
        do_reset();
        wr(16'hFE06, 16'h0058);
        mmio_addr = 16'hFE04;
        #1;
        checks++;
        if (dsp_valid !== 1'b1 || dsp_data !== 8'h58 || mmio_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL ddr_load got dv=%b dd=%h dsr=%h exp 1 58 0000", dsp_valid, dsp_data, mmio_rdata);
        end
        wr(16'hFE06, 16'h0059);
        mmio_addr = 16'hFE06;
        #1;
        checks++;
        if (dsp_data !== 8'h58 || mmio_rdata !== 16'h0058) begin
            errors++;
            $display("FAIL ddr_drop got dd=%h ddr=%h exp 58 0058", dsp_data, mmio_rdata);
        end
        dsp_ready = 1;
        step();
        dsp_ready = 0;
        mmio_addr = 16'hFE04;
        #1;
        checks++;
        if (dsp_valid !== 1'b0 || mmio_rdata !== 16'h8000) begin
            errors++;
            $display("FAIL dsp_xfer got dv=%b dsr=%h exp 0 8000", dsp_valid, mmio_rdata);
        end
        wr(16'hFE06, 16'h005A);
        dsp_ready = 1;
        wr(16'hFE06, 16'h005B);
        dsp_ready = 0;
        checks++;
        if (dsp_valid !== 1'b1 || dsp_data !== 8'h5B) begin
            errors++;
            $display("FAIL ddr_reload got dv=%b dd=%h exp 1 5b", dsp_valid, dsp_data);
        end
    endtask

    task automatic test_priority();
        do_reset();
        wr(16'hFE04, 16'h4000);
        wr(16'hFE00, 16'h4000);
        push(8'h11);
        step();
        step();
        checks++;
        if (intp !== 3'd4 || intv !== 8'h80) begin
            errors++;
            $display("FAIL prio_kbd got intp=%0d intv=%h exp 4 80", intp, intv);
        end
        checks++;
        if (t_intp !== 3'd3 || t_intv !== 8'h80) begin
            errors++;
            $display("FAIL prio_tie got intp=%0d intv=%h exp 3 80", t_intp, t_intv);
        end
        wr(16'hFE00, 16'h0000);
        checks++;
        if (intp !== 3'd4 || irq !== 1'b0) begin
            errors++;
            $display("FAIL prio_latency got intp=%0d irq=%b exp 4 0", intp, irq);
        end
        step();
        checks++;
        if (intp !== 3'd3 || intv !== 8'h81 || irq !== 1'b1) begin
            errors++;
            $display("FAIL prio_dsp got intp=%0d intv=%h irq=%b exp 3 81 1", intp, intv, irq);
        end
        checks++;
        if (t_intp !== 3'd3 || t_intv !== 8'h81 || t_irq !== 1'b1) begin
            errors++;
            $display("FAIL prio_tie_dsp got intp=%0d intv=%h irq=%b exp 3 81 1", t_intp, t_intv, t_irq);
        end
        step();
        checks++;
        if (irq !== 1'b0 || t_irq !== 1'b0) begin
            errors++;
            $display("FAIL prio_irq_once got irq=%b tie_irq=%b exp 0 0", irq, t_irq);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        wr(16'hFE00, 16'h4000);
        wr(16'hFE06, 16'h0033);
        push(8'h21);
        push(8'h22);
        step();
        #2;
        rst = 1;
        model_reset();
        mmio_addr = 16'hFE00;
        #1;
        checks++;
        if (mmio_rdata !== 16'h0000 || intp !== 3'd0 || dsp_valid !== 1'b0 || dsp_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got st=%h intp=%0d dv=%b dd=%h exp 0000 0 0 00",
                     mmio_rdata, intp, dsp_valid, dsp_data);
        end
        step();
        rst = 0;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            checks++;
            if (kbd_ready !== (mq.size() < 4) || dsp_valid !== m_dv || dsp_data !== m_dd) begin
                errors++;
                $display("FAIL rand_status cyc %0d got kr=%b dv=%b dd=%h exp %b %b %h",
                         n, kbd_ready, dsp_valid, dsp_data, (mq.size() < 4), m_dv, m_dd);
            end
            checks++;
            if (intp !== m_intp || intv !== m_intv || irq !== m_irq) begin
                errors++;
                $display("FAIL rand_irq cyc %0d got %0d %h %b exp %0d %h %b",
                         n, intp, intv, irq, m_intp, m_intv, m_irq);
            end
            r = $urandom_range(0, 4);
            mmio_addr  = (r == 4) ? 16'($urandom) : 16'hFE00 + 16'(2 * r);
            mmio_wdata = 16'($urandom);
            mmio_load  = ($urandom_range(0, 9) < 2);
            mmio_rd    = ($urandom_range(0, 9) < 5);
            kbd_valid  = ($urandom_range(0, 9) < 4);
            kbd_data   = 8'($urandom);
            dsp_ready  = ($urandom_range(0, 9) < 3);
            #1;
            checks++;
            if (mmio_rdata !== m_read(mmio_addr)) begin
                errors++;
                $display("FAIL rand_rdata cyc %0d addr %h got %h exp %h",
                         n, mmio_addr, mmio_rdata, m_read(mmio_addr));
            end
            step();
        end
        mmio_load = 0; mmio_rd = 0; kbd_valid = 0; dsp_ready = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_kbd_fifo();
        test_overflow();
        test_kbd_irq();
        test_display();
        test_priority();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
